// File: rtl/mux_arb_pkg.sv
// Shared types for the two-way round-robin stream arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/mux2_1.sv
// One-bit 2:1 mux cell; the arbiter builds its datapath from an array of these.
module mux2_1 (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output logic y
);

  assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel between two streams.
// A grant lasts for a whole packet (up to *_last) or MAX_BEATS beats, whichever
// comes first, then priority rotates. The datapath is a per-bit mux2_1 array
// steered by the registered sel.
// Optional: define MUX_ARB_STATS_EN to add grant_cnt0/grant_cnt1 grant counters.
module mux2_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in0_valid,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sel,
  output logic                  busy
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]    grant_cnt0,
  output logic [STATS_W-1:0]    grant_cnt1
`endif
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int MW    = DATA_WIDTH + 2;

  arb_state_t       state_q, state_d;
  logic             prio_q, prio_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant, grant_idx;
  logic             cur, cur_valid, oth_valid;
  logic             xfer, quota_hit;

  // Datapath: {valid, last, data} for both sides, one mux cell per bit.
  logic [MW-1:0] mux_a, mux_b, mux_y;
  logic          mux_valid;

  assign mux_a = {in0_valid, in0_last, in0_data};
  assign mux_b = {in1_valid, in1_last, in1_data};

  genvar b;
  generate
    for (b = 0; b < MW; b++) begin : g_mux
      mux2_1 u_mux (
        .i0  (mux_a[b]),
        .i1  (mux_b[b]),
        .sel (sel_q),
        .y   (mux_y[b])
      );
    end
  endgenerate

  assign mux_valid = mux_y[MW-1];
  assign out_last  = mux_y[MW-2];
  assign out_data  = mux_y[DATA_WIDTH-1:0];

  // sel always matches the granted side while busy, so the mux output is the
  // granted stream; IDLE just blanks valid.
  assign busy      = (state_q != IDLE);
  assign out_valid = busy & mux_valid;
  assign in0_ready = (state_q == GRANT0) & out_ready;
  assign in1_ready = (state_q == GRANT1) & out_ready;
  assign sel       = sel_q;

  assign cur       = (state_q == GRANT1);
  assign cur_valid = cur ? in1_valid : in0_valid;
  assign oth_valid = cur ? in0_valid : in1_valid;
  assign xfer      = out_valid & out_ready;
  assign quota_hit = (cnt_q == CNT_W'(MAX_BEATS - 1));

  // Next-state: arbitration from IDLE, beat counting and release/handover.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    grant_idx = 1'b0;
    case (state_q)
      IDLE: begin
        if (in0_valid | in1_valid) begin
          grant     = 1'b1;
          grant_idx = (in0_valid & in1_valid) ? prio_q : in1_valid;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          if (out_last | quota_hit) begin
            // Handover prefers the other side; the current side's valid is
            // high on its own transfer edge, so it keeps the grant otherwise.
            prio_d = ~cur;
            cnt_d  = '0;
            if (oth_valid) begin
              grant     = 1'b1;
              grant_idx = ~cur;
            end else if (cur_valid) begin
              grant     = 1'b1;
              grant_idx = cur;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = grant_idx ? GRANT1 : GRANT0;
      sel_d   = grant_idx;
      cnt_d   = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MUX_ARB_STATS_EN
  // Saturating per-requester grant-edge counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (grant) begin
      if (!grant_idx && grant_cnt0 != {STATS_W{1'b1}}) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (grant_idx && grant_cnt1 != {STATS_W{1'b1}})  grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter (MAX_BEATS=4): cycle model checked every negedge plus
// literal transfer-order/timing expectations for directed scenarios.
module tb_mux2_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in0_valid = 1'b0, in0_last = 1'b0, in1_valid = 1'b0, in1_last = 1'b0;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          out_ready = 1'b0;
  logic          in0_ready, in1_ready, out_valid, out_last, sel, busy;
  logic [DW-1:0] out_data;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
`ifdef MUX_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Producer queues: {last, data}
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  // Accepted-beat log: {src, data} and the cycle it happened
  logic [8:0] log_q[$];
  int         log_c[$];
  logic [8:0] exp_q[$];
  int         cyc = 0;

  // Model: owner (-1 = none), rotating priority, beats in current grant
  int own = -1, prio = 0, msel = 0, beats = 0;
  int gcnt0 = 0, gcnt1 = 0;

  always @(negedge clk) begin
    logic v[2];
    logic l[2];
    logic [DW-1:0] d[2];
    logic ev;
    int o;
    cyc++;
    v[0] = in0_valid; v[1] = in1_valid;
    l[0] = in0_last;  l[1] = in1_last;
    d[0] = in0_data;  d[1] = in1_data;
    ev = (own >= 0) ? v[own] : 1'b0;
    chk("busy", busy, own >= 0);
    chk("out_valid", out_valid, ev);
    chk("sel", sel, msel[0]);
    chk("in0_ready", in0_ready, own == 0 && out_ready);
    chk("in1_ready", in1_ready, own == 1 && out_ready);
    if (ev) begin
      chk("out_data", out_data, d[own]);
      chk("out_last", out_last, l[own]);
    end
`ifdef MUX_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, gcnt0);
    chk("grant_cnt1", grant_cnt1, gcnt1);
`endif
    if (out_valid && out_ready) begin
      log_q.push_back({sel, out_data});
      log_c.push_back(cyc);
    end
    // advance the model across the coming rising edge
    o = -1;
    if (!rst_n) begin
      own = -1; prio = 0; msel = 0; beats = 0; gcnt0 = 0; gcnt1 = 0;
    end else if (own < 0) begin
      if (v[0] || v[1]) o = (v[0] && v[1]) ? prio : (v[1] ? 1 : 0);
    end else if (v[own] && out_ready) begin
      beats++;
      if (l[own] || beats == MB) begin
        prio = 1 - own;
        beats = 0;
        if (v[1 - own]) o = 1 - own;
        else if (v[own]) o = own;
        else own = -1;
      end
    end
    if (o >= 0) begin
      own = o; msel = o; beats = 0;
      if (o == 0 && gcnt0 < 65535) gcnt0++;
      if (o == 1 && gcnt1 < 65535) gcnt1++;
    end
  end

  task automatic drive();
    in0_valid = q0.size() > 0;
    in0_data  = (q0.size() > 0) ? q0[0][7:0] : '0;
    in0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    in1_valid = q1.size() > 0;
    in1_data  = (q1.size() > 0) ? q1[0][7:0] : '0;
    in1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  // One clock: note handshakes before the edge, pop them after it.
  task automatic step();
    logic h0, h1;
    @(negedge clk);
    h0 = in0_valid & in0_ready & rst_n;
    h1 = in1_valid & in1_ready & rst_n;
    @(posedge clk);
    #1;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    drive();
    step(); step();
    rst_n = 1'b1;
    log_q.delete(); log_c.delete();
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 60) begin
      step();
      n++;
    end
    chk({nm, " drain"}, n < 60, 1'b1);
    step(); step();
  endtask

  task automatic wait_log(input string nm, input int cnt);
    int n = 0;
    while (log_q.size() < cnt && n < 30) begin
      step();
      n++;
    end
    chk({nm, " wait"}, n < 30, 1'b1);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, " count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s beat%0d", nm, i), log_q[i], exp_q[i]);
  endtask

  task automatic chk_back2back(input string nm);
    for (int i = 1; i < log_c.size(); i++)
      chk($sformatf("%s gap%0d", nm, i), log_c[i] - log_c[i-1], 1);
  endtask

  initial begin
    int t0;
    out_ready = 1'b1;

    // Reset values
    do_reset();
    chk("rst sel", sel, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst in0_ready", in0_ready, 1'b0);
    chk("rst in1_ready", in1_ready, 1'b0);

    // Single requester: A1..A3, one cycle arbitration then back-to-back
    q0 = '{9'h0A1, 9'h0A2, 9'h1A3};
    drive();
    t0 = cyc;
    drain("single");
    exp_q = '{9'h0A1, 9'h0A2, 9'h0A3};
    chk_log("single");
    for (int i = 0; i < log_c.size(); i++)
      chk($sformatf("single cyc%0d", i), log_c[i], t0 + 2 + i);
    chk("single quiet", out_valid, 1'b0);

    // Contention: in0 first, in1 handover with no bubble, then in0 again
    do_reset();
    q0 = '{9'h0B1, 9'h1B2, 9'h0B3, 9'h1B4};
    q1 = '{9'h0C1, 9'h1C2};
    drive();
    drain("contend");
    exp_q = '{9'h0B1, 9'h0B2, 9'h1C1, 9'h1C2, 9'h0B3, 9'h0B4};
    chk_log("contend");
    chk_back2back("contend");

    // Quota: 6-beat packet split after 4 beats, in1 served in between
    do_reset();
    q0 = '{9'h0D1, 9'h0D2, 9'h0D3, 9'h0D4, 9'h0D5, 9'h1D6};
    q1 = '{9'h0E1, 9'h1E2};
    drive();
    drain("quota");
    exp_q = '{9'h0D1, 9'h0D2, 9'h0D3, 9'h0D4, 9'h1E1, 9'h1E2, 9'h0D5, 9'h0D6};
    chk_log("quota");
    chk_back2back("quota");

    // Backpressure: 3 stalled cycles after F2 must not count toward the quota
    do_reset();
    q0 = '{9'h0F1, 9'h0F2, 9'h0F3, 9'h0F4, 9'h1F5};
    q1 = '{9'h1C7};
    drive();
    wait_log("bp", 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp data held", out_data, 8'hF3);
      chk("bp valid held", out_valid, 1'b1);
      chk("bp in0_ready", in0_ready, 1'b0);
    end
    out_ready = 1'b1;
    drain("bp");
    exp_q = '{9'h0F1, 9'h0F2, 9'h0F3, 9'h0F4, 9'h1C7, 9'h0F5};
    chk_log("bp");
    if (log_c.size() >= 3) chk("bp stall gap", log_c[2] - log_c[1], 4);

    // Reset mid-packet after beat 2 of 4; packet restarts cleanly
    do_reset();
    q0 = '{9'h091, 9'h092, 9'h093, 9'h194};
    drive();
    wait_log("mid", 2);
    rst_n = 1'b0;
    q0.delete();
    drive();
    step();
    rst_n = 1'b1;
    chk("mid busy", busy, 1'b0);
    chk("mid sel", sel, 1'b0);
    q0 = '{9'h091, 9'h092, 9'h093, 9'h194};
    q1 = '{9'h1AA};
    drive();
    drain("mid");
    exp_q = '{9'h091, 9'h092, 9'h091, 9'h092, 9'h093, 9'h094, 9'h1AA};
    chk_log("mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
